// File: rtl/counter_multimode_pkg.sv
// rtl/counter_multimode_pkg.sv - mode and one-shot state encodings for counter_multimode
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP_WRAP   = 2'd0,
    MODE_DOWN_WRAP = 2'd1,
    MODE_UP_SAT    = 2'd2,
    MODE_ONE_SHOT  = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/counter_multimode_if.sv
// rtl/counter_multimode_if.sv - control and status bundle of counter_multimode
interface counter_multimode_if #(
  parameter int WIDTH = 8
);

  logic             EN;
  logic             LOAD;
  logic [WIDTH-1:0] VALUE;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] TOP;
  logic [WIDTH-1:0] C;
  logic             TC;
  logic             RUNNING;

  modport master (
    output EN, LOAD, VALUE, MODE, TOP,
    input  C, TC, RUNNING
  );

  modport slave (
    input  EN, LOAD, VALUE, MODE, TOP,
    output C, TC, RUNNING
  );

endinterface

// File: rtl/counter_multimode.sv
// rtl/counter_multimode.sv - four-mode counter with registered count, terminal pulse and one-shot
module counter_multimode
  import counter_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
`ifdef USE_POWER_PINS
  inout wire                  vccd1,
  inout wire                  vssd1,
`endif
  input  logic                CLK,
  input  logic                RESET,
  counter_multimode_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] c_q, c_d;
  logic             tc_q, tc_d;
  state_e           state_q, state_d;
  mode_e            mode;

  assign mode = mode_e'(bus.MODE);

  always_comb begin
    c_d     = c_q;
    tc_d    = 1'b0;
    state_d = state_q;
    // Leaving one-shot mode always abandons a pending one-shot run.
    if (mode != MODE_ONE_SHOT) begin
      state_d = IDLE;
    end
    if (bus.LOAD) begin
      c_d = bus.VALUE;
      if (mode == MODE_ONE_SHOT) begin
        state_d = (bus.VALUE != '0) ? RUN : IDLE;
      end
    end else if (bus.EN) begin
      case (mode)
        MODE_UP_WRAP: begin
          if (c_q >= bus.TOP) begin
            c_d  = '0;
            tc_d = 1'b1;
          end else begin
            c_d = c_q + ONE;
          end
        end
        MODE_DOWN_WRAP: begin
          if (c_q == '0) begin
            c_d  = bus.TOP;
            tc_d = 1'b1;
          end else begin
            c_d = c_q - ONE;
          end
        end
        MODE_UP_SAT: begin
          if (c_q < bus.TOP) begin
            c_d  = c_q + ONE;
            tc_d = ((c_q + ONE) == bus.TOP);
          end
        end
        MODE_ONE_SHOT: begin
          // A run sitting at zero cannot occur from a load; drop it quietly if it does.
          if (state_q == RUN) begin
            if (c_q <= ONE) begin
              c_d     = '0;
              tc_d    = (c_q == ONE);
              state_d = IDLE;
            end else begin
              c_d = c_q - ONE;
            end
          end
        end
        default: begin
          c_d = c_q;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      c_q     <= RESET_VALUE;
      tc_q    <= 1'b0;
      state_q <= IDLE;
    end else begin
      c_q     <= c_d;
      tc_q    <= tc_d;
      state_q <= state_d;
    end
  end

  assign bus.C       = c_q;
  assign bus.TC      = tc_q;
  assign bus.RUNNING = (state_q == RUN);

endmodule

// File: tb/tb_counter_multimode.sv
// tb/tb_counter_multimode.sv - directed scoreboard bench for counter_multimode
module tb_counter_multimode;
  import counter_pkg::*;

  typedef struct {
    string       tag;
    int          dut;
    logic [31:0] c;
    logic        tc;
    logic        run;
  } exp_t;

  logic CLK;
  logic RESET;
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  counter_multimode_if #(.WIDTH(8)) bus8 ();
  counter_multimode_if #(.WIDTH(4)) bus4 ();

  counter_multimode #(.WIDTH(8), .RESET_VALUE(8'h10)) dut8 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus8.slave)
  );

  counter_multimode #(.WIDTH(4)) dut4 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus4.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick_check();
    exp_t        e;
    logic [31:0] oc;
    logic        otc, orun;
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      if (e.dut == 8) begin
        oc = {24'b0, bus8.C}; otc = bus8.TC; orun = bus8.RUNNING;
      end else begin
        oc = {28'b0, bus4.C}; otc = bus4.TC; orun = bus4.RUNNING;
      end
      check({e.tag, ".C"}, oc, e.c);
      check({e.tag, ".TC"}, {31'b0, otc}, {31'b0, e.tc});
      check({e.tag, ".RUNNING"}, {31'b0, orun}, {31'b0, e.run});
    end
  endtask

  task automatic s8(input string tag, input logic rst, input logic en, input logic ld,
                    input logic [7:0] val, input logic [1:0] mode, input logic [7:0] top,
                    input logic [7:0] ec, input logic etc, input logic erun);
    exp_t e;
    RESET = rst; bus8.EN = en; bus8.LOAD = ld; bus8.VALUE = val; bus8.MODE = mode; bus8.TOP = top;
    e.tag = tag; e.dut = 8; e.c = {24'b0, ec}; e.tc = etc; e.run = erun;
    sb.push_back(e);
    tick_check();
  endtask

  task automatic s4(input string tag, input logic rst, input logic en, input logic ld,
                    input logic [3:0] val, input logic [1:0] mode, input logic [3:0] top,
                    input logic [3:0] ec, input logic etc, input logic erun);
    exp_t e;
    RESET = rst; bus4.EN = en; bus4.LOAD = ld; bus4.VALUE = val; bus4.MODE = mode; bus4.TOP = top;
    e.tag = tag; e.dut = 4; e.c = {28'b0, ec}; e.tc = etc; e.run = erun;
    sb.push_back(e);
    tick_check();
  endtask

  initial begin
    RESET = 1'b1;
    bus4.EN = 1'b0; bus4.LOAD = 1'b0; bus4.VALUE = '0; bus4.MODE = 2'd0; bus4.TOP = '0;
    bus8.EN = 1'b0; bus8.LOAD = 1'b0; bus8.VALUE = '0; bus8.MODE = 2'd0; bus8.TOP = '0;

    // reset overrides simultaneous load and enable
    s8("rst_load", 1, 1, 1, 8'hAA, MODE_UP_WRAP, 8'h05, 8'h10, 0, 0);
    s4("rst4",     1, 1, 0, 4'h0,  MODE_UP_WRAP, 4'h5,  4'h0,  0, 0);
    s8("load_aa",  0, 0, 1, 8'hAA, MODE_UP_WRAP, 8'h05, 8'hAA, 0, 0);

    // UP_WRAP, TOP=5
    s8("uw_load0", 0, 1, 1, 8'h00, MODE_UP_WRAP, 8'h05, 8'h00, 0, 0);
    for (int i = 1; i <= 5; i++)
      s8("uw_cnt", 0, 1, 0, 8'h00, MODE_UP_WRAP, 8'h05, 8'(i), 0, 0);
    s8("uw_wrap",  0, 1, 0, 8'h00, MODE_UP_WRAP, 8'h05, 8'h00, 1, 0);
    s8("uw_after", 0, 1, 0, 8'h00, MODE_UP_WRAP, 8'h05, 8'h01, 0, 0);
    s8("uw_hold",  0, 0, 0, 8'h00, MODE_UP_WRAP, 8'h05, 8'h01, 0, 0);
    s8("uw_top0a", 0, 1, 0, 8'h00, MODE_UP_WRAP, 8'h00, 8'h00, 1, 0);
    s8("uw_top0b", 0, 1, 0, 8'h00, MODE_UP_WRAP, 8'h00, 8'h00, 1, 0);
    s8("uw_to5",   0, 1, 1, 8'h05, MODE_UP_WRAP, 8'h05, 8'h05, 0, 0);
    s8("uw_ld_tc", 0, 1, 1, 8'h05, MODE_UP_WRAP, 8'h05, 8'h05, 0, 0);
    s8("uw_wrap2", 0, 1, 0, 8'h00, MODE_UP_WRAP, 8'h05, 8'h00, 1, 0);
    s8("uw_ff_ld", 0, 0, 1, 8'hFF, MODE_UP_WRAP, 8'hFF, 8'hFF, 0, 0);
    s8("uw_ff",    0, 1, 0, 8'h00, MODE_UP_WRAP, 8'hFF, 8'h00, 1, 0);

    // DOWN_WRAP, TOP=9
    s8("dw_load2", 0, 0, 1, 8'h02, MODE_DOWN_WRAP, 8'h09, 8'h02, 0, 0);
    s8("dw_1",     0, 1, 0, 8'h00, MODE_DOWN_WRAP, 8'h09, 8'h01, 0, 0);
    s8("dw_0",     0, 1, 0, 8'h00, MODE_DOWN_WRAP, 8'h09, 8'h00, 0, 0);
    s8("dw_wrap",  0, 1, 0, 8'h00, MODE_DOWN_WRAP, 8'h09, 8'h09, 1, 0);
    s8("dw_8",     0, 1, 0, 8'h00, MODE_DOWN_WRAP, 8'h09, 8'h08, 0, 0);
    s8("dw_hold",  0, 0, 0, 8'h00, MODE_DOWN_WRAP, 8'h09, 8'h08, 0, 0);

    // UP_SAT, TOP=3
    s8("us_load0", 0, 0, 1, 8'h00, MODE_UP_SAT, 8'h03, 8'h00, 0, 0);
    s8("us_1",     0, 1, 0, 8'h00, MODE_UP_SAT, 8'h03, 8'h01, 0, 0);
    s8("us_2",     0, 1, 0, 8'h00, MODE_UP_SAT, 8'h03, 8'h02, 0, 0);
    s8("us_3",     0, 1, 0, 8'h00, MODE_UP_SAT, 8'h03, 8'h03, 1, 0);
    s8("us_sat_a", 0, 1, 0, 8'h00, MODE_UP_SAT, 8'h03, 8'h03, 0, 0);
    s8("us_sat_b", 0, 1, 0, 8'h00, MODE_UP_SAT, 8'h03, 8'h03, 0, 0);

    // ONE_SHOT
    s8("os_load3", 0, 0, 1, 8'h03, MODE_ONE_SHOT, 8'h00, 8'h03, 0, 1);
    s8("os_2",     0, 1, 0, 8'h00, MODE_ONE_SHOT, 8'h00, 8'h02, 0, 1);
    s8("os_1",     0, 1, 0, 8'h00, MODE_ONE_SHOT, 8'h00, 8'h01, 0, 1);
    s8("os_done",  0, 1, 0, 8'h00, MODE_ONE_SHOT, 8'h00, 8'h00, 1, 0);
    s8("os_idle",  0, 1, 0, 8'h00, MODE_ONE_SHOT, 8'h00, 8'h00, 0, 0);
    s8("os_load0", 0, 1, 1, 8'h00, MODE_ONE_SHOT, 8'h00, 8'h00, 0, 0);
    s8("os_ld3b",  0, 0, 1, 8'h03, MODE_ONE_SHOT, 8'h00, 8'h03, 0, 1);
    s8("os_en0",   0, 0, 0, 8'h00, MODE_ONE_SHOT, 8'h00, 8'h03, 0, 1);
    s8("os_2b",    0, 1, 0, 8'h00, MODE_ONE_SHOT, 8'h00, 8'h02, 0, 1);
    s8("os_reset", 1, 1, 0, 8'h00, MODE_ONE_SHOT, 8'h00, 8'h10, 0, 0);
    s8("os_ld5",   0, 0, 1, 8'h05, MODE_ONE_SHOT, 8'h00, 8'h05, 0, 1);
    s8("os_4",     0, 1, 0, 8'h00, MODE_ONE_SHOT, 8'h00, 8'h04, 0, 1);
    s8("os_mode0", 0, 0, 0, 8'h00, MODE_UP_WRAP,  8'h09, 8'h04, 0, 0);

    // WIDTH=4 boundary and mode switch out of RUN
    s4("w4_loade", 0, 0, 1, 4'hE, MODE_UP_WRAP, 4'hF, 4'hE, 0, 0);
    s4("w4_f",     0, 1, 0, 4'h0, MODE_UP_WRAP, 4'hF, 4'hF, 0, 0);
    s4("w4_wrap",  0, 1, 0, 4'h0, MODE_UP_WRAP, 4'hF, 4'h0, 1, 0);
    s4("w4_1",     0, 1, 0, 4'h0, MODE_UP_WRAP, 4'hF, 4'h1, 0, 0);
    s4("w4_os5",   0, 0, 1, 4'h5, MODE_ONE_SHOT, 4'hF, 4'h5, 0, 1);
    s4("w4_sw0",   0, 1, 0, 4'h0, MODE_UP_WRAP, 4'hF, 4'h6, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
